parity_frame_receiver: RTL and testbench

PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

---
 rtl/parity_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_parity_frame_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver
// Receives 11-bit serial frames (start, 8 data bits LSB first, even parity,
// stop) from a line that is already synchronous to clk, and reports each
// completed frame with a one-cycle data_valid pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level (start bit)
// START     | counting to mid start bit; high there means a glitch
// DATA      | sampling the 8 data bits at mid-bit, LSB first
// PARITY    | sampling the parity bit at mid-bit
// STOP      | sampling the stop bit at mid-bit, then reporting the frame
// WAIT_HIGH | stop bit was low; waiting for the line to return high
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   serial_in  : serial line, idle high, synchronous to clk
//   data_out   : last received data byte
//   data_valid : one-cycle pulse for each completed frame
//   parity_err : parity status of the last frame (1 = mismatch)
//   frame_err  : stop-bit status of the last frame (1 = stop bit low)
//   busy       : high in every state except IDLE

module parity_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // The counter is cleared on the edge that detects the start bit and at
    // each sample point, so a sample falls on the edge where it reaches
    // (period - 1).
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        par_bit;
    logic        sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!serial_in) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                sample = (cnt == HALF_LAST);
                if (sample) begin
                    state_next = serial_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                sample = (cnt == BIT_LAST);
                if (sample && (bit_idx == 3'd7)) begin
                    state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                sample = (cnt == BIT_LAST);
                if (sample) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                sample = (cnt == BIT_LAST);
                if (sample) begin
                    state_next = serial_in ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (serial_in) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 16'd0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            if ((state == S_IDLE) || (state == S_WAIT_HIGH) || sample) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if (state == S_IDLE) begin
                bit_idx <= 3'd0;
            end else if ((state == S_DATA) && sample) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // Shift in at the MSB so the first (LSB) bit ends at bit 0.
            if ((state == S_DATA) && sample) begin
                shift <= {serial_in, shift[7:1]};
            end

            if ((state == S_PARITY) && sample) begin
                par_bit <= serial_in;
            end

            if ((state == S_STOP) && sample) begin
                data_valid <= 1'b1;
                data_out   <= shift;
                parity_err <= (^shift) ^ par_bit;
                frame_err  <= ~serial_in;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver
// Self-checking bench for parity_frame_receiver with CLKS_PER_BIT = 4.
// The driver serialises frames and pushes the expected report (byte, error
// flags and the cycle on which the pulse must appear) into a queue; a
// monitor on the falling edge pops and compares on every data_valid and
// checks that the reported outputs hold between pulses.

module tb_parity_frame_receiver;

    localparam int unsigned CPB  = 4;
    localparam int unsigned HALF = CPB / 2;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    parity_frame_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          total;
    int          bad;
    logic [7:0]  last_d;
    logic        last_pe;
    logic        last_fe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reference values come only from the queue and reset rule.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_d  = 8'h00;
            last_pe = 1'b0;
            last_fe = 1'b0;
        end else if (data_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got data_valid=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", data_out, e.d);
                chk("parity_err", parity_err, e.pe);
                chk("frame_err", frame_err, e.fe);
                chk("valid_cycle", cyc, e.cyc);
                last_d  = e.d;
                last_pe = e.pe;
                last_fe = e.fe;
            end
        end else begin
            chk("hold_data", data_out, last_d);
            chk("hold_perr", parity_err, last_pe);
            chk("hold_ferr", frame_err, last_fe);
        end
    end

    // Driver is always positioned 1 time unit after a rising edge.
    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        exp_t e;
        // The first edge to see the start bit is the next one.
        e.cyc = cyc + 1 + HALF + 10 * CPB;
        e.d   = d;
        e.pe  = (pbit != (^d));
        e.fe  = (stop == 1'b0);
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stop);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle_cycles(3);

        // Good frame and parity-error frame.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_cycles(2);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_cycles(2);

        // Frame error: line stays low after the stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ferr_busy_low", busy, 1);
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        chk("ferr_busy_released", busy, 0);
        idle_cycles(2);

        // One-cycle glitch is rejected at the mid-start sample.
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        chk("glitch_busy", busy, 1);
        repeat (HALF + 2) @(posedge clk);
        #1;
        chk("glitch_idle", busy, 0);
        chk("glitch_data", data_out, 8'h3C);
        idle_cycles(2);

        // Back-to-back frames.
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_cycles(3);

        // Reset during data bit 4.
        serial_in = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_perr", parity_err, 0);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_busy", busy, 0);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycles(2);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_cycles(2);

        // Random frames with occasional parity and stop errors.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       pbit;
            logic       stop;
            d    = 8'($urandom);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, pbit, stop);
            if (!stop) idle_cycles(2 + $urandom_range(0, 3));
            else       idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(20);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
